pipe_gap_picker: RTL



---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_gap_picker_if.sv | 15 +
 rtl/gap_fifo.sv | 69 ++++++
 rtl/pipe_gap_picker.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipe gap picker: FSM state encoding,
// gap geometry constants and the gap word type.
package pipe_pkg;

  localparam int RND_W_DEF      = 13;
  localparam int OUT_W_DEF      = 10;
  localparam int GAP_MIN_DEF    = 80;
  localparam int GAP_RANGE_DEF  = 240;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int MAX_DELTA_DEF  = 60;

  typedef logic [OUT_W_DEF-1:0] gap_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    PUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_gap_picker_if.sv
// Gap-position stream from the picker to the pipe/scroll logic.
//
// Handshake: a transfer happens on a rising clock edge where gap_valid and
// gap_ready are both 1. While gap_valid=1 and gap_ready=0, gap_y is held
// stable. gap_ready with gap_valid=0 has no effect.
interface pipe_gap_picker_if #(
  parameter int OUT_W = 10
);
  logic             gap_valid;
  logic             gap_ready;
  logic [OUT_W-1:0] gap_y;

  modport master (output gap_valid, output gap_y, input gap_ready);
  modport slave  (input gap_valid, input gap_y, output gap_ready);
endinterface

// File: rtl/gap_fifo.sv
// Small synchronous FIFO for gap entries. The head entry is kept in a
// register so the consumer sees a flop output.
module gap_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [LW-1:0] level_nxt;
  logic          do_pop;
  logic          do_push;

  assign valid     = (level != '0);
  assign do_pop    = pop && valid && !flush;
  assign do_push   = push && !flush && ((level != FULL_LVL) || do_pop);
  assign rd_nxt    = rd_ptr + AW'(do_pop);
  assign level_nxt = level + LW'(do_push) - LW'(do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      data   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_nxt;
      level  <= level_nxt;
      // A push landing in the new head slot bypasses the array write.
      if (level_nxt != '0) begin
        if (do_push && (wr_ptr == rd_nxt)) begin
          data <= push_data;
        end else begin
          data <= mem[rd_nxt];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_gap_picker.sv
// Samples the LFSR stream, reduces it modulo GAP_RANGE by repeated
// subtraction and queues GAP_MIN-offset gap positions. Optional step
// clamping between consecutive gaps is enabled by GAP_DELTA_LIMIT_EN.
module pipe_gap_picker
  import pipe_pkg::*;
#(
  parameter int RND_W      = RND_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int GAP_MIN    = GAP_MIN_DEF,
  parameter int GAP_RANGE  = GAP_RANGE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
`ifdef GAP_DELTA_LIMIT_EN
  , parameter int MAX_DELTA = MAX_DELTA_DEF
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [RND_W-1:0]            rnd,
  input  logic                        flush,
  pipe_gap_picker_if.master           gap,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output state_t                      dbg_state,
  output logic [RND_W-1:0]            dbg_acc
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [RND_W-1:0] RANGE_R  = RND_W'(GAP_RANGE);
  localparam logic [OUT_W-1:0] MIN_O    = OUT_W'(GAP_MIN);

  state_t           state;
  logic [RND_W-1:0] acc;
  logic             push;
  logic [OUT_W-1:0] raw_gap;
  logic [OUT_W-1:0] wr_val;

  assign dbg_state = state;
  assign dbg_acc   = acc;
  assign push      = (state == PUSH) && !flush;
  // acc is below GAP_RANGE in PUSH, so the truncation keeps every set bit.
  assign raw_gap   = MIN_O + OUT_W'(acc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      busy  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (level < FULL_LVL) begin
            acc   <= rnd;
            state <= REDUCE;
            busy  <= 1'b1;
          end
        end
        REDUCE: begin
          if (acc >= RANGE_R) begin
            acc <= acc - RANGE_R;
          end else begin
            state <= PUSH;
          end
        end
        PUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GAP_DELTA_LIMIT_EN
  localparam logic [OUT_W:0] MIN_X   = (OUT_W+1)'(GAP_MIN);
  localparam logic [OUT_W:0] MAX_X   = (OUT_W+1)'(GAP_MIN + GAP_RANGE - 1);
  localparam logic [OUT_W:0] DELTA_X = (OUT_W+1)'(MAX_DELTA);

  logic [OUT_W-1:0] last_gap;
  logic             have_last;
  logic [OUT_W:0]   last_x;
  logic [OUT_W:0]   cand_x;
  logic [OUT_W:0]   lo_x;
  logic [OUT_W:0]   hi_x;

  // Window is computed one bit wider so last_gap +/- MAX_DELTA cannot wrap.
  always_comb begin
    last_x = {1'b0, last_gap};
    cand_x = {1'b0, raw_gap};
    lo_x   = (last_x >= MIN_X + DELTA_X) ? (last_x - DELTA_X) : MIN_X;
    hi_x   = (last_x + DELTA_X <= MAX_X) ? (last_x + DELTA_X) : MAX_X;
    wr_val = raw_gap;
    if (have_last) begin
      if (cand_x < lo_x) begin
        wr_val = OUT_W'(lo_x);
      end else if (cand_x > hi_x) begin
        wr_val = OUT_W'(hi_x);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_gap  <= '0;
      have_last <= 1'b0;
    end else if (flush) begin
      last_gap  <= '0;
      have_last <= 1'b0;
    end else if (push) begin
      last_gap  <= wr_val;
      have_last <= 1'b1;
    end
  end
`else
  assign wr_val = raw_gap;
`endif

  gap_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (wr_val),
    .pop       (gap.gap_ready),
    .flush     (flush),
    .data      (gap.gap_y),
    .valid     (gap.gap_valid),
    .level     (level)
  );

endmodule
